// File: rtl/arb_pkg.sv
// Shared constants and state type for the four-source round-robin mux arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package arb_pkg;

    localparam int N_SRC = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick_4.sv
// Round-robin picker: first set req bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
//
// Ports:
//   req   [3:0] in   request vector
//   ptr   [1:0] in   last granted index; the scan starts just after it
//   found       out  at least one req bit is set
//   idx   [1:0] out  chosen index (holds ptr when found=0)
module rr_pick_4
    import arb_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        // k=N_SRC wraps back to ptr itself, so the last owner has lowest priority.
        for (int k = 1; k <= N_SRC; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_sel_arbiter_4.sv
// Round-robin arbiter driving the select of a shared 4:1 mux, up to BURST beats per grant.
// Latency: req seen in IDLE -> out_valid next cycle; one IDLE bubble between grants.
// Backpressure: out_ready=0 holds sel and the beat count; no ack until the beat moves.
//
// Ports:
//   clk             in   clock, all state on posedge
//   rst             in   synchronous reset, active-high
//   req       [3:0] in   source i has a valid beat on its mux input
//   ack       [3:0] out  source i's beat transferred this cycle (one-hot or 0)
//   sel       [1:0] out  registered mux select / granted source index
//   out_valid       out  mux output holds a valid beat
//   out_ready       in   consumer accepts the beat this cycle
module rr_sel_arbiter_4
    import arb_pkg::*;
#(
    parameter int BURST = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req,
    output logic [N_SRC-1:0] ack,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready
);

    arb_state_t       state, state_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             xfer;

    rr_pick_4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            ptr      <= SEL_W'(N_SRC - 1);   // first search then starts at source 0
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            ptr      <= ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Next-state logic. sel only changes on the IDLE->GRANT transition, so
    // requests arriving mid-grant are simply picked up in the next IDLE cycle.
    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        ptr_nxt      = ptr;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    sel_nxt      = pick_idx;
                    ptr_nxt      = pick_idx;
                    beat_cnt_nxt = '0;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    state_nxt = IDLE;
                end else if (xfer) begin
                    if (beat_cnt == CNT_W'(BURST - 1)) begin
                        state_nxt = IDLE;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode. Masking with rst means a beat offered in the reset cycle
    // is never acked, since the grant it belongs to is being discarded.
    always_comb begin
        out_valid = (state == GRANT) && req[sel] && !rst;
        xfer      = out_valid && out_ready;
        ack       = '0;
        if (xfer) begin
            ack[sel] = 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter_4.sv
module tb_rr_sel_arbiter_4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req_a, req_b;
    logic       out_ready;
    logic [3:0] ack_a, ack_b;
    logic [1:0] sel_a, sel_b;
    logic       ov_a, ov_b;

    rr_sel_arbiter_4 #(.BURST(4), .CNT_W(4)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .req       (req_a),
        .ack       (ack_a),
        .sel       (sel_a),
        .out_valid (ov_a),
        .out_ready (out_ready)
    );

    rr_sel_arbiter_4 #(.BURST(1), .CNT_W(1)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .req       (req_b),
        .ack       (ack_b),
        .sel       (sel_b),
        .out_valid (ov_b),
        .out_ready (out_ready)
    );

    // Reference model: who owns the mux, how many beats it has moved, who was last served.
    typedef struct {
        int         owner;   // -1 when nobody holds a grant
        int         beats;
        int         last;
        logic [1:0] sel;
    } model_t;

    typedef struct {
        logic       ov;
        logic [1:0] sel;
        logic [3:0] ack;
    } exp_t;

    exp_t       cq_a[$], cq_b[$];
    logic [1:0] xq_a[$], xq_b[$];
    logic [1:0] glog[$];
    logic       log_b = 1'b0;
    model_t     m_a, m_b;
    logic [3:0] last_ack_a = '0, last_ack_b = '0;
    int         checks = 0;
    int         errors = 0;

    function automatic model_t model_reset();
        model_t m;
        m.owner = -1;
        m.beats = 0;
        m.last  = 3;
        m.sel   = 2'd0;
        return m;
    endfunction

    task automatic model_step(input int burst, inout model_t m, input logic r,
                              input logic [3:0] rq, input logic rdy, output exp_t e);
        bit got;
        e.ov  = 1'b0;
        e.ack = 4'd0;
        e.sel = m.sel;
        if (!r && m.owner >= 0) begin
            e.ov = rq[m.owner];
            if (e.ov && rdy) e.ack = 4'd1 << m.owner;
        end
        if (r) begin
            m = model_reset();
        end else if (m.owner < 0) begin
            got = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m.last + k) % 4;
                if (!got && rq[c]) begin
                    got     = 1'b1;
                    m.owner = c;
                    m.last  = c;
                    m.beats = 0;
                    m.sel   = 2'(c);
                end
            end
        end else if (!rq[m.owner]) begin
            m.owner = -1;
        end else if (e.ack != 4'd0) begin
            m.beats++;
            if (m.beats == burst) m.owner = -1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, predict this cycle's outputs, queue them.
    task automatic cycle(input logic r, input logic [3:0] ra, input logic [3:0] rb, input logic rdy);
        exp_t ea, eb;
        @(posedge clk);
        #1;
        rst       = r;
        req_a     = ra;
        req_b     = rb;
        out_ready = rdy;
        model_step(4, m_a, r, ra, rdy, ea);
        model_step(1, m_b, r, rb, rdy, eb);
        cq_a.push_back(ea);
        cq_b.push_back(eb);
        if (ea.ack != 4'd0) xq_a.push_back(ea.sel);
        if (eb.ack != 4'd0) xq_b.push_back(eb.sel);
        last_ack_a = ea.ack;
        last_ack_b = eb.ack;
    endtask

    // Monitor: per-cycle valid/select check, and transfer check whenever the DUT moves a beat.
    always @(negedge clk) begin : mon
        exp_t       e;
        logic [1:0] s;
        if (cq_a.size() > 0) begin
            e = cq_a.pop_front();
            chk("a_out_valid", int'(ov_a), int'(e.ov));
            chk("a_sel", int'(sel_a), int'(e.sel));
        end
        if (ov_a && out_ready) begin
            if (xq_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_xfer unexpected beat from sel=%0d at %0t", sel_a, $time);
            end else begin
                s = xq_a.pop_front();
                chk("a_xfer_sel", int'(sel_a), int'(s));
                chk("a_ack", int'(ack_a), int'(4'd1 << s));
            end
        end else begin
            chk("a_ack_quiet", int'(ack_a), 0);
        end

        if (cq_b.size() > 0) begin
            e = cq_b.pop_front();
            chk("b_out_valid", int'(ov_b), int'(e.ov));
            chk("b_sel", int'(sel_b), int'(e.sel));
        end
        if (ov_b && out_ready) begin
            if (log_b) glog.push_back(sel_b);
            if (xq_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_xfer unexpected beat from sel=%0d at %0t", sel_b, $time);
            end else begin
                s = xq_b.pop_front();
                chk("b_xfer_sel", int'(sel_b), int'(s));
                chk("b_ack", int'(ack_b), int'(4'd1 << s));
            end
        end else begin
            chk("b_ack_quiet", int'(ack_b), 0);
        end
    end

    initial begin : stim
        logic [3:0] ra, rb;
        logic       r, rdy;
        rst       = 1'b1;
        req_a     = 4'hF;
        req_b     = 4'hF;
        out_ready = 1'b1;
        m_a       = model_reset();
        m_b       = model_reset();

        // Held in reset with everyone requesting: nothing may be granted.
        repeat (4) cycle(1'b1, 4'hF, 4'hF, 1'b1);

        // A: single source, BURST=4 -> 4 beats, bubble, regrant.
        // B: all sources, BURST=1 -> pure rotation starting at 0.
        log_b = 1'b1;
        repeat (14) cycle(1'b0, 4'b0001, 4'b1111, 1'b1);
        @(negedge clk);
        log_b = 1'b0;
        chk("b_rotation_len", int'(glog.size() >= 6), 1);
        foreach (glog[i]) chk("b_rotation_order", int'(glog[i]), i % 4);

        // Backpressure in the middle of a burst on A.
        repeat (3) cycle(1'b0, 4'b0000, 4'b0000, 1'b1);
        repeat (2) cycle(1'b0, 4'b0010, 4'b0000, 1'b1);
        repeat (5) cycle(1'b0, 4'b0010, 4'b0000, 1'b0);
        repeat (6) cycle(1'b0, 4'b0010, 4'b0000, 1'b1);

        // Last grant was source 1: with 1 and 2 waiting, 2 goes first, then 1.
        repeat (2) cycle(1'b0, 4'b0000, 4'b0000, 1'b1);
        repeat (12) cycle(1'b0, 4'b0110, 4'b0110, 1'b1);

        // Reset during beat 2 of a grant to source 3, then 0 and 3 compete.
        repeat (3) cycle(1'b0, 4'b0000, 4'b0000, 1'b1);
        repeat (3) cycle(1'b0, 4'b1000, 4'b1000, 1'b1);
        cycle(1'b1, 4'b1000, 4'b1000, 1'b1);
        repeat (8) cycle(1'b0, 4'b1001, 4'b1001, 1'b1);

        // Randomised traffic; sources normally hold req until acked.
        ra = 4'b1001;
        rb = 4'b1001;
        for (int i = 0; i < 3000; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (ra[j]) begin
                    if ((last_ack_a[j] && $urandom_range(1, 0) == 0) || $urandom_range(99, 0) < 2)
                        ra[j] = 1'b0;
                end else if ($urandom_range(99, 0) < 30) begin
                    ra[j] = 1'b1;
                end
                if (rb[j]) begin
                    if ((last_ack_b[j] && $urandom_range(1, 0) == 0) || $urandom_range(99, 0) < 2)
                        rb[j] = 1'b0;
                end else if ($urandom_range(99, 0) < 30) begin
                    rb[j] = 1'b1;
                end
            end
            r   = ($urandom_range(199, 0) == 0);
            rdy = ($urandom_range(99, 0) < 70);
            cycle(r, ra, rb, rdy);
        end

        repeat (3) cycle(1'b0, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("a_pending_beats", xq_a.size(), 0);
        chk("b_pending_beats", xq_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
